// File: rtl/problema1_button_pio.sv
// -----------------------------------------------------------------------------
// problema1_button_pio
// Avalon-MM input PIO for push-buttons/switches: per-channel 2-flop
// synchroniser, optional debouncer, edge-capture register (RW1C) and a
// maskable level interrupt.
//
// Optional feature macro: PROBLEMA1_BUTTON_PIO_DEBOUNCE_EN
//   defined   -> per-channel debounce counter qualifies every level change
//   undefined -> accepted state is the synced input registered once
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   address    in   [1:0] register select (0 data, 1 reserved, 2 irqmask,
//                   3 edgecapture)
//   chipselect in   slave select
//   write_n    in   active-low write strobe, qualified by chipselect
//   writedata  in   [31:0] write data, bits above WIDTH ignored
//   in_port    in   [WIDTH-1:0] raw asynchronous pin levels
//   readdata   out  [31:0] registered read data, zero-extended
//   irq        out  level interrupt, OR of edgecapture & irqmask
// -----------------------------------------------------------------------------
module problema1_button_pio #(
    parameter int unsigned     WIDTH           = 4,
    parameter int unsigned     EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IDLE_LEVEL     = '1,
    parameter int unsigned     DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_dly_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] edge_det;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;

    // Upper writedata bits and the debounce length are intentionally unused
    // in some configurations.
    logic unused_ok;
    assign unused_ok = ^{writedata, 1'(DEBOUNCE_CYCLES)};

    assign wr_en = chipselect & ~write_n;

    // Two-flop synchroniser; idle reset level avoids a spurious edge at reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

`ifdef PROBLEMA1_BUTTON_PIO_DEBOUNCE_EN
    localparam int unsigned CNT_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Count cycles the synced level disagrees with the accepted level; any
    // agreeing cycle restarts qualification.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != acc_q[i]) begin
                if (cnt_q[i] == CNT_TOP) begin
                    acc_d[i] = ~acc_q[i];
                end else if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    always_comb begin
        acc_d = sync2_q;
    end
`endif

    // Edge detect on the accepted level against its one-cycle-old copy.
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = acc_q & ~acc_dly_q;
            1:       edge_det = ~acc_q & acc_dly_q;
            default: edge_det = acc_q ^ acc_dly_q;
        endcase
    end

    // Register writes; a fresh edge overrides a same-cycle W1C clear.
    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        if (wr_en && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end
        edge_d = edge_d | edge_det;
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = 32'(acc_q);
            2'd2:    readdata_d = 32'(mask_q);
            2'd3:    readdata_d = 32'(edge_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= IDLE_LEVEL;
            acc_dly_q  <= IDLE_LEVEL;
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
        end else begin
            acc_q      <= acc_d;
            acc_dly_q  <= acc_q;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule

// File: doc/problema1_button_pio.md
# problema1_button_pio

Parametrised Avalon-MM input PIO for push-buttons and switches. It is the successor of the 2-bit data-only button port, generalised to `WIDTH` channels. Each channel adds a 2-flop synchroniser, an optional debouncer, a per-bit edge-capture register and a maskable interrupt. It sits between the board's button pins and the Nios II system interconnect as an `s1` Avalon slave with an `irq` sender.

## Interface
Parameters:
- `WIDTH`, 4: number of input channels (1..32).
- `EDGE_TYPE`, 1: captured edge. 0 = rising, 1 = falling, 2 = any.
- `IDLE_LEVEL`, all-ones (`WIDTH` bits): reset value of the synchroniser and debounced state. Buttons idle high.
- `DEBOUNCE_CYCLES`, 50000: cycles a new level must persist before acceptance (≥2). Used only with the debounce feature.

Ports (one clock `clk`; reset `reset_n` is asynchronous, active-low):
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave selected.
- `write_n`  in  1  active-low write strobe, qualified by `chipselect`.
- `writedata`  in  32  write data; bits above `WIDTH` ignored.
- `in_port`  in  `WIDTH`  raw asynchronous pin levels.
- `readdata`  out  32  registered read data, zero-extended.
- `irq`  out  1  level interrupt, active-high.

## Operation
- Register map:
  - 0: `data`, RO. Debounced level.
  - 1: reserved, reads 0, writes ignored.
  - 2: `irqmask`, RW. A 1 enables that channel's interrupt.
  - 3: `edgecapture`, RW1C.
- Synchroniser: two flops per channel, both reset to `IDLE_LEVEL`. This guarantees no spurious edge out of reset.
- Debouncer (when compiled in), per channel:
  - An 8..32-bit saturating counter (width `$clog2(DEBOUNCE_CYCLES+1)`).
  - While the synced input differs from the accepted state, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES - 1`, the accepted state toggles and the counter clears.
  - Any cycle where the synced input equals the accepted state clears the counter.
- Edge detect: compares the accepted state with its 1-cycle-delayed copy and applies `EDGE_TYPE`. A detected edge sets the `edgecapture` bit.
- Edge-capture clear: a write to address 3 clears each bit where `writedata` is 1. Bits where `writedata` is 0 are untouched.
- Simultaneous edge and clear on the same bit in the same cycle: the set wins and the bit stays 1.
- `irqmask` write: loads `writedata[WIDTH-1:0]`.
- `irq` = OR-reduce(`edgecapture & irqmask`). Combinational from registers, so glitch-free.
- `readdata`: registered every cycle from the address mux, independent of `chipselect`. Read has no side effects.
- Reset values:
  - `readdata` = 0, `irqmask` = 0, `edgecapture` = 0, `irq` = 0.
  - Debounce counters = 0; accepted state = `IDLE_LEVEL`.
- Reset mid-debounce: partial counts are discarded and the pin must be re-qualified after release.

## Timing
- Pin change to synced value: 2 cycles.
- Synced value to accepted state: 1 cycle without debounce. With debounce, `DEBOUNCE_CYCLES` cycles.
- Accepted state to `edgecapture` bit set: 1 cycle. `irq` rises in the same cycle as that bit.
- Total pin-to-`irq` latency: 4 cycles without debounce; `DEBOUNCE_CYCLES + 3` with debounce.
- Read latency: 1 cycle. `readdata` reflects the register value at the previous rising edge, so wait-states = 1.
- Write: takes effect at the rising edge where `chipselect & ~write_n` holds. `irq` deasserts on the next cycle after a clearing write.
- Pulses shorter than `DEBOUNCE_CYCLES` are rejected entirely.

## Configuration
- Macro `PROBLEMA1_BUTTON_PIO_DEBOUNCE_EN`.
- Defined: debouncer is instantiated as described.
- Undefined: accepted state = synced input registered once. `DEBOUNCE_CYCLES` is ignored and no counters are synthesised.

## Test plan
- Reset: assert `reset_n` = 0 mid-run with `in_port` = 4'b1111. Required: all outputs 0; reading addresses 0/2/3 after release returns 0xF / 0x0 / 0x0; no `irq`.
- Falling edge, `DEBOUNCE_CYCLES` = 4, debounce on: drive `in_port[1]` 1→0 and hold. Required: `edgecapture` = 0x2 at cycle 7; `irq` stays 0 with `irqmask` = 0. After writing `irqmask` = 0x2, `irq` = 1 on the next cycle.
- Bounce rejection: toggle `in_port[0]` low for 3 cycles, then high, with `DEBOUNCE_CYCLES` = 4. Required: `data` and `edgecapture` unchanged, `irq` = 0.
- RW1C: with `edgecapture` = 0xA, write 0x8 to address 3. Required: reading address 3 returns 0x2; `irq` (mask 0xF) stays 1. Writing 0x2 then drops `irq` the next cycle.
- Simultaneous set/clear: schedule the edge detect on bit 2 in the same cycle as a write of 0x4 to address 3. Required: `edgecapture[2]` = 1 afterwards.
- Macro undefined, `EDGE_TYPE` = 2: a 1-cycle low pulse on `in_port[3]`. Required: both edges detected, `edgecapture` = 0x8, and `irq` asserted 4 cycles after the first pin change with mask 0x8.
